// File: rtl/sub32_seq_pkg.sv
// Shared sizing and FSM encoding for the multi-cycle digit-serial subtractor.
package sub32_seq_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DIGIT_W = 8;
  localparam int unsigned N       = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/sub32_seq_if.sv
// Start/done request bus carrying operands in and difference plus flags out.
interface sub32_seq_if #(
  parameter int unsigned Width = 32
);

  logic             start;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [Width-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf, zero
  );

endinterface

// File: rtl/sub32_seq_digit_sub.sv
// Combinational ripple-borrow subtractor over one digit, built from full-subtractor cells.
module digit_sub #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             bin_i,
  output logic [Width-1:0] d_o,
  output logic             bout_o
);

  logic [Width:0] borrow;

  assign borrow[0] = bin_i;

  for (genvar i = 0; i < Width; i++) begin : gen_cell
    assign d_o[i]        = a_i[i] ^ b_i[i] ^ borrow[i];
    assign borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
  end

  assign bout_o = borrow[Width];

endmodule

// File: rtl/sub32_seq.sv
// Digit-serial a - b - bin: one DigitW slice per clock through a shared digit_sub,
// borrow carried in a register between slices.
module sub32_seq
  import sub32_seq_pkg::*;
#(
  parameter int unsigned Width  = WIDTH,
  parameter int unsigned DigitW = DIGIT_W
) (
  input logic        clk,
  input logic        rst,
  sub32_seq_if.slave bus
);

  localparam int unsigned NDig = Width / DigitW;
  localparam int unsigned CntW = (NDig > 1) ? $clog2(NDig) : 1;

  if ((Width % DigitW) != 0) begin : gen_width_chk
    $error("DigitW must divide Width");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic [Width-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic              bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  int unsigned       slice_idx;
  logic [DigitW-1:0] dig_a, dig_b, dig_d;
  logic              dig_bout;
  logic              last_dig;

  assign slice_idx = 32'(cnt_q) * DigitW;
  assign dig_a     = a_q[slice_idx +: DigitW];
  assign dig_b     = b_q[slice_idx +: DigitW];
  assign last_dig  = (cnt_q == CntW'(NDig - 1));

  digit_sub #(
    .Width(DigitW)
  ) u_digit_sub (
    .a_i   (dig_a),
    .b_i   (dig_b),
    .bin_i (borrow_q),
    .d_o   (dig_d),
    .bout_o(dig_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_dig) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Results are only ever written slice by slice; untouched bits keep the prior result.
  always_comb begin
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
        end
      end
      StRun: begin
        res_d[slice_idx +: DigitW] = dig_d;
        borrow_d                   = dig_bout;
        cnt_d                      = cnt_q + CntW'(1);
        if (last_dig) begin
          bout_d = dig_bout;
          ovf_d  = (a_q[Width-1] ^ b_q[Width-1]) & (a_q[Width-1] ^ res_d[Width-1]);
          zero_d = ~|res_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
    bus.d    = res_q;
    bus.bout = bout_q;
    bus.ovf  = ovf_q;
    bus.zero = zero_q;
  end

endmodule

// File: tb/tb_sub32_seq.sv
// Directed and random checks of the digit-serial subtractor with default sizing (N = 4).
module tb_sub32_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sub32_seq_if #(.Width(32)) bus ();

  sub32_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation from IDLE; returns edges from accept to done (-1 on timeout),
  // and leaves the DUT back in IDLE one edge after the done pulse.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 32'h5;
    bus.b     = 32'h3;
    bus.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.d, bus.bout, bus.ovf, bus.zero} !== 37'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b d=%h bout=%b ovf=%b zero=%b want all 0",
               bus.busy, bus.done, bus.d, bus.bout, bus.ovf, bus.zero);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd5;
    bus.b     = 32'd3;
    bus.bin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL basic_run%0d: busy=%b done=%b want 1 0", k, bus.busy, bus.done);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b want 1 0", bus.done, bus.busy);
    end
    checks++;
    if ({bus.d, bus.bout, bus.ovf, bus.zero} !== {32'h2, 3'b000}) begin
      errors++;
      $display("FAIL basic_result: d=%h bout=%b ovf=%b zero=%b want 00000002 0 0 0",
               bus.d, bus.bout, bus.ovf, bus.zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.d !== 32'h2) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b d=%h want 0 0 00000002",
               bus.done, bus.busy, bus.d);
    end
  endtask

  task automatic test_underflow();
    int lat;
    do_op(32'h0, 32'h1, 1'b0, lat);
    checks++;
    if (lat !== 4 || {bus.d, bus.bout, bus.ovf, bus.zero} !== {32'hFFFF_FFFF, 3'b100}) begin
      errors++;
      $display("FAIL underflow_0m1: lat=%0d d=%h bout=%b ovf=%b zero=%b want 4 ffffffff 1 0 0",
               lat, bus.d, bus.bout, bus.ovf, bus.zero);
    end
    do_op(32'h0000_00FF, 32'h0000_0100, 1'b0, lat);
    checks++;
    if (lat !== 4 || {bus.d, bus.bout, bus.ovf, bus.zero} !== {32'hFFFF_FFFF, 3'b100}) begin
      errors++;
      $display("FAIL underflow_digit: lat=%0d d=%h bout=%b ovf=%b zero=%b want 4 ffffffff 1 0 0",
               lat, bus.d, bus.bout, bus.ovf, bus.zero);
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(32'h8000_0000, 32'h1, 1'b0, lat);
    checks++;
    if (lat !== 4 || {bus.d, bus.bout, bus.ovf, bus.zero} !== {32'h7FFF_FFFF, 3'b010}) begin
      errors++;
      $display("FAIL ovf_neg: lat=%0d d=%h bout=%b ovf=%b zero=%b want 4 7fffffff 0 1 0",
               lat, bus.d, bus.bout, bus.ovf, bus.zero);
    end
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    checks++;
    if (lat !== 4 || {bus.d, bus.bout, bus.ovf, bus.zero} !== {32'h8000_0000, 3'b110}) begin
      errors++;
      $display("FAIL ovf_pos: lat=%0d d=%h bout=%b ovf=%b zero=%b want 4 80000000 1 1 0",
               lat, bus.d, bus.bout, bus.ovf, bus.zero);
    end
  endtask

  task automatic test_zero_bin();
    int lat;
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, lat);
    checks++;
    if (lat !== 4 || {bus.d, bus.bout, bus.ovf, bus.zero} !== {32'h0, 3'b001}) begin
      errors++;
      $display("FAIL zero: lat=%0d d=%h bout=%b ovf=%b zero=%b want 4 00000000 0 0 1",
               lat, bus.d, bus.bout, bus.ovf, bus.zero);
    end
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, lat);
    checks++;
    if (lat !== 4 || {bus.d, bus.bout, bus.ovf, bus.zero} !== {32'hFFFF_FFFF, 3'b100}) begin
      errors++;
      $display("FAIL zero_bin: lat=%0d d=%h bout=%b ovf=%b zero=%b want 4 ffffffff 1 0 0",
               lat, bus.d, bus.bout, bus.ovf, bus.zero);
    end
  endtask

  task automatic test_ignored_start();
    int dones;
    int lat;
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd10;
    bus.b     = 32'd4;
    bus.bin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
      if (k == 1) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd2;
      end else if (k == 2) begin
        bus.start = 1'b0;
      end else if (k == 4) begin
        checks++;
        if (bus.done !== 1'b1 || bus.d !== 32'd6) begin
          errors++;
          $display("FAIL ignored_result: done=%b d=%h want 1 00000006", bus.done, bus.d);
        end
        bus.start = 1'b1;
      end else if (k == 5) begin
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL ignored_done_start: busy=%b want 0", bus.busy);
        end
      end
    end
    checks++;
    if (dones !== 1 || bus.busy !== 1'b0 || bus.d !== 32'd6) begin
      errors++;
      $display("FAIL ignored_single: dones=%0d busy=%b d=%h want 1 0 00000006",
               dones, bus.busy, bus.d);
    end
    do_op(32'd1, 32'd2, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.d !== 32'hFFFF_FFFF || bus.bout !== 1'b1) begin
      errors++;
      $display("FAIL ignored_fresh: lat=%0d d=%h bout=%b want 4 ffffffff 1",
               lat, bus.d, bus.bout);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int lat;
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h0;
    bus.b     = 32'h1;
    bus.bin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.d, bus.bout, bus.ovf, bus.zero} !== 37'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b d=%h bout=%b ovf=%b zero=%b want all 0",
               bus.busy, bus.done, bus.d, bus.bout, bus.ovf, bus.zero);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: dones=%0d busy=%b want 0 0", dones, bus.busy);
    end
    do_op(32'd9, 32'd9, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.d !== 32'h0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next: lat=%0d d=%h zero=%b want 4 00000000 1",
               lat, bus.d, bus.zero);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp_d;
    logic        bin, exp_bout, exp_ovf;
    logic [32:0] full;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a   = $urandom;
      b   = (i % 5 == 0) ? a : $urandom;
      bin = 1'($urandom_range(0, 1));
      full     = {1'b0, a} - {1'b0, b} - {32'b0, bin};
      exp_d    = full[31:0];
      exp_bout = full[32];
      exp_ovf  = (a[31] ^ b[31]) & (a[31] ^ exp_d[31]);
      do_op(a, b, bin, lat);
      checks++;
      if (lat !== 4 || bus.d !== exp_d || bus.bout !== exp_bout || bus.ovf !== exp_ovf ||
          bus.zero !== (exp_d == 32'h0)) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h bin=%b lat=%0d d=%h bout=%b ovf=%b zero=%b want 4 %h %b %b %b",
                 i, a, b, bin, lat, bus.d, bus.bout, bus.ovf, bus.zero,
                 exp_d, exp_bout, exp_ovf, (exp_d == 32'h0));
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_zero_bin();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
